// File: rtl/audio_pwm_out_if.sv
// Stereo sample handshake between the audio sample FIFO (master) and the PWM output stage (slave).
`timescale 1ns/1ps

interface audio_pwm_out_if #(
  parameter int SAMPLE_WIDTH = 8
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    sample_ready;

  modport master (
    output sample_valid,
    output sample_left,
    output sample_right,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_left,
    input  sample_right,
    output sample_ready
  );
endinterface

// File: rtl/audio_pwm_out.sv
// Stereo PWM output stage: one FIFO sample per PERIOD-clock frame, one holding buffer plus active duty.
// Optional saturating underrun counter port when AUDIOX_UNDERRUN_CNT_EN is defined.
`timescale 1ns/1ps

module audio_pwm_out #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PERIOD       = 255
) (
  input  logic           sys_clock,
  input  logic           reset_,
  input  logic           enable,
  audio_pwm_out_if.slave smp,
  output logic           audio_left,
  output logic           audio_right,
  output logic           frame_start,
  output logic           underrun
`ifdef AUDIOX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]    underrun_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [SAMPLE_WIDTH-1:0] CNT_ZERO = {SAMPLE_WIDTH{1'b0}};
  localparam logic [SAMPLE_WIDTH-1:0] CNT_LAST = SAMPLE_WIDTH'(PERIOD - 1);

  state_e                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;
  logic [SAMPLE_WIDTH-1:0] duty_l_q, duty_l_d;
  logic [SAMPLE_WIDTH-1:0] duty_r_q, duty_r_d;
  logic                    buf_full_q, buf_full_d;
  logic                    audio_l_q, audio_l_d;
  logic                    audio_r_q, audio_r_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic                    ready_s;
  logic                    accept_s;

  assign ready_s          = (state_q != ST_IDLE) & ~buf_full_q;
  assign accept_s         = smp.sample_valid & ready_s;
  assign smp.sample_ready = ready_s;

  assign audio_left  = audio_l_q;
  assign audio_right = audio_r_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // Next-state logic: buffer capture, frame sequencing and the PWM compare
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    buf_full_d    = buf_full_q;
    duty_l_d      = duty_l_q;
    duty_r_d      = duty_r_q;
    audio_l_d     = 1'b0;
    audio_r_d     = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (accept_s) begin
      buf_l_d    = smp.sample_left;
      buf_r_d    = smp.sample_right;
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end

    if (!enable) begin
      // Disable flushes the buffer but keeps the duty pair
      state_d    = ST_IDLE;
      cnt_d      = CNT_ZERO;
      buf_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          cnt_d   = CNT_ZERO;
        end
        ST_PRIME: begin
          cnt_d = CNT_ZERO;
          if (buf_full_q) begin
            state_d       = ST_RUN;
            duty_l_d      = buf_l_q;
            duty_r_d      = buf_r_q;
            buf_full_d    = 1'b0;
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_PRIME;
          end
        end
        ST_RUN: begin
          audio_l_d = (cnt_q < duty_l_q);
          audio_r_d = (cnt_q < duty_r_q);
          if (cnt_q == CNT_LAST) begin
            cnt_d         = CNT_ZERO;
            frame_start_d = 1'b1;
            // An empty buffer at the boundary repeats the last sample; a same-cycle accept waits a frame
            if (buf_full_q) begin
              duty_l_d   = buf_l_q;
              duty_r_d   = buf_r_q;
              buf_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          buf_full_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge sys_clock or negedge reset_) begin
    if (!reset_) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      buf_l_q       <= CNT_ZERO;
      buf_r_q       <= CNT_ZERO;
      buf_full_q    <= 1'b0;
      duty_l_q      <= CNT_ZERO;
      duty_r_q      <= CNT_ZERO;
      audio_l_q     <= 1'b0;
      audio_r_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      buf_full_q    <= buf_full_d;
      duty_l_q      <= duty_l_d;
      duty_r_q      <= duty_r_d;
      audio_l_q     <= audio_l_d;
      audio_r_q     <= audio_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef AUDIOX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun tally; only reset_ clears it
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underrun counter register
  always_ff @(posedge sys_clock or negedge reset_) begin
    if (!reset_) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule
